// File: rtl/vga_pkg.sv
// Shared raster constants and pixel type for the 640x480 @ 60 Hz VGA timing generator.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef logic [11:0] rgb444_t;

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register with a configurable reset level; depth 0 is a plain wire.
module sync_delay #(
  parameter int   DEPTH   = 1,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q = d;
    end else begin : g_chain
      logic [DEPTH-1:0] sr;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sr <= {DEPTH{RST_VAL}};
        end else begin
          sr[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            sr[i] <= sr[i-1];
          end
        end
      end

      assign q = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster timing generator: scan counters, strobes and delayed sync/blank outputs.
// Optional blanking of pixel_out outside active video is enabled by defining VGA_BLANK_RGB_EN.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter int   PIPE_DLY = 1,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk_25MHz,
  input  logic       rst_n,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       valid,
  output logic       valid_d,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt,
  output logic       hsync,
  output logic       vsync,
  input  rgb444_t    pixel_in,
  output rgb444_t    pixel_out
);

  localparam int LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(LINE_LEN - 1);
  localparam logic [9:0] V_LAST   = 10'(FRAME_LINES - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic running;
  logic hs_raw;
  logic vs_raw;

  // running holds the counters for exactly one edge after reset release.
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      running   <= 1'b0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else begin
      running <= 1'b1;
      if (running) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          if (v_cnt == V_LAST) begin
            v_cnt     <= '0;
            frame_cnt <= frame_cnt + 8'd1;
          end else begin
            v_cnt <= v_cnt + 10'd1;
          end
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  assign valid       = running && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign line_start  = running && (h_cnt == '0);
  assign frame_start = line_start && (v_cnt == '0);

  assign hs_raw = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
  assign vs_raw = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? SYNC_POL : ~SYNC_POL;

  sync_delay #(.DEPTH(PIPE_DLY), .RST_VAL(~SYNC_POL)) u_hs_dly (
    .clk   (clk_25MHz),
    .rst_n (rst_n),
    .d     (hs_raw),
    .q     (hsync)
  );

  sync_delay #(.DEPTH(PIPE_DLY), .RST_VAL(~SYNC_POL)) u_vs_dly (
    .clk   (clk_25MHz),
    .rst_n (rst_n),
    .d     (vs_raw),
    .q     (vsync)
  );

  sync_delay #(.DEPTH(PIPE_DLY), .RST_VAL(1'b0)) u_valid_dly (
    .clk   (clk_25MHz),
    .rst_n (rst_n),
    .d     (valid),
    .q     (valid_d)
  );

`ifdef VGA_BLANK_RGB_EN
  assign pixel_out = valid_d ? pixel_in : rgb444_t'(12'h000);
`else
  assign pixel_out = pixel_in;
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen on a shrunken raster so whole frames and the 256-frame wrap fit in a short run.
module tb_vga_scan_gen;

  localparam int   HA = 8, HFP = 2, HS = 3, HBP = 3;
  localparam int   VA = 6, VFP = 1, VS = 2, VBP = 2;
  localparam int   D = 2;
  localparam logic POL = 1'b0;
  localparam int   HT = HA + HFP + HS + HBP;
  localparam int   VT = VA + VFP + VS + VBP;
  localparam int   FRAME = HT * VT;

  logic        clk_25MHz = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] pixel_in = 12'h000;
  logic [9:0]  h_cnt, v_cnt;
  logic [7:0]  frame_cnt;
  logic        valid, valid_d, line_start, frame_start, hsync, vsync;
  logic [11:0] pixel_out;

  int checks = 0;
  int failures = 0;
  int cyc = -1;

  vga_scan_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .PIPE_DLY(D), .SYNC_POL(POL)
  ) dut (
    .clk_25MHz   (clk_25MHz),
    .rst_n       (rst_n),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .valid       (valid),
    .valid_d     (valid_d),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt),
    .hsync       (hsync),
    .vsync       (vsync),
    .pixel_in    (pixel_in),
    .pixel_out   (pixel_out)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  wire [45:0] obs = {h_cnt, v_cnt, frame_cnt, valid, valid_d, line_start,
                     frame_start, hsync, vsync, pixel_out};

  // Reference model: k = edges since reset release (k = 0 is the first edge, k < 0 is idle).
  function automatic int exp_h(int k);
    return (k < 0) ? 0 : k % HT;
  endfunction

  function automatic int exp_v(int k);
    return (k < 0) ? 0 : (k / HT) % VT;
  endfunction

  function automatic int exp_f(int k);
    return (k < 0) ? 0 : (k / FRAME) % 256;
  endfunction

  function automatic logic exp_valid(int k);
    return (k >= 0) && (exp_h(k) < HA) && (exp_v(k) < VA);
  endfunction

  function automatic logic exp_vd(int k);
    return (k - D < 0) ? 1'b0 : exp_valid(k - D);
  endfunction

  function automatic logic exp_hs(int k);
    int h;
    if (k - D < 0) return ~POL;
    h = exp_h(k - D);
    return (h >= HA + HFP && h < HA + HFP + HS) ? POL : ~POL;
  endfunction

  function automatic logic exp_vs(int k);
    int v;
    if (k - D < 0) return ~POL;
    v = exp_v(k - D);
    return (v >= VA + VFP && v < VA + VFP + VS) ? POL : ~POL;
  endfunction

  function automatic logic [11:0] exp_pix(int k, logic [11:0] pin);
`ifdef VGA_BLANK_RGB_EN
    return exp_vd(k) ? pin : 12'h000;
`else
    return pin;
`endif
  endfunction

  function automatic logic [45:0] exp_vec(int k, logic [11:0] pin);
    logic ls, fs;
    ls = (k >= 0) && (exp_h(k) == 0);
    fs = ls && (exp_v(k) == 0);
    return {10'(exp_h(k)), 10'(exp_v(k)), 8'(exp_f(k)), exp_valid(k), exp_vd(k),
            ls, fs, exp_hs(k), exp_vs(k), exp_pix(k, pin)};
  endfunction

  task automatic tick();
    @(posedge clk_25MHz);
    cyc++;
    @(negedge clk_25MHz);
  endtask

  task automatic test_reset();
    logic [45:0] rst_vec;
    rst_vec = {10'd0, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, ~POL, ~POL, 12'h000};
    rst_n = 1'b0;
    pixel_in = 12'h000;
    repeat (3) @(negedge clk_25MHz);
    #1;
    checks++;
    if (obs !== rst_vec) begin
      failures++;
      $display("FAIL reset_state: got %h expected %h", obs, rst_vec);
    end
  endtask

  task automatic test_release();
    rst_n = 1'b1;
    cyc = -1;
    #1;
    checks++;
    if (h_cnt !== 10'd0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL release_pre_edge: h_cnt=%0d valid=%b expected h_cnt=0 valid=0", h_cnt, valid);
    end
    tick();
    checks++;
    if (h_cnt !== 10'd0 || valid !== 1'b1) begin
      failures++;
      $display("FAIL release_cycle0: h_cnt=%0d valid=%b expected h_cnt=0 valid=1", h_cnt, valid);
    end
    tick();
    checks++;
    if (h_cnt !== 10'd1) begin
      failures++;
      $display("FAIL release_cycle1: h_cnt=%0d expected 1", h_cnt);
    end
  endtask

  task automatic test_scan(input int n);
    logic [45:0] e;
    for (int i = 0; i < n; i++) begin
      pixel_in = 12'($urandom_range(0, 4095));
      #1;
      e = exp_vec(cyc, pixel_in);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL scan k=%0d: got %h expected %h", cyc, obs, e);
      end
      tick();
    end
  endtask

  task automatic test_line_wrap();
    bit found = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (exp_h(cyc) == HT - 1 && exp_v(cyc) == 5) begin
        found = 1;
        break;
      end
      if (exp_h(cyc) >= HA) begin
        checks++;
        if (valid !== 1'b0) begin
          failures++;
          $display("FAIL blank_valid k=%0d h=%0d: valid=%b expected 0", cyc, h_cnt, valid);
        end
      end
      tick();
    end
    checks++;
    if (!found || h_cnt !== 10'(HT - 1) || v_cnt !== 10'd5) begin
      failures++;
      $display("FAIL line_wrap_reach: h=%0d v=%0d expected h=%0d v=5", h_cnt, v_cnt, HT - 1);
    end
    tick();
    checks++;
    if (h_cnt !== 10'd0 || v_cnt !== 10'd6 || line_start !== 1'b1) begin
      failures++;
      $display("FAIL line_wrap: h=%0d v=%0d ls=%b expected h=0 v=6 ls=1", h_cnt, v_cnt, line_start);
    end
  endtask

  task automatic test_sync();
    for (int i = 0; i < FRAME + 4; i++) begin
      checks++;
      if (hsync !== exp_hs(cyc) || vsync !== exp_vs(cyc) || valid_d !== exp_vd(cyc)) begin
        failures++;
        $display("FAIL sync k=%0d: hs/vs/vd=%b%b%b expected %b%b%b", cyc, hsync, vsync, valid_d,
                 exp_hs(cyc), exp_vs(cyc), exp_vd(cyc));
      end
      tick();
    end
  endtask

  task automatic test_blank();
    logic [11:0] e;
    pixel_in = 12'hF0F;
    for (int i = 0; i < 2 * HT; i++) begin
      #1;
`ifdef VGA_BLANK_RGB_EN
      e = exp_vd(cyc) ? 12'hF0F : 12'h000;
`else
      e = 12'hF0F;
`endif
      checks++;
      if (pixel_out !== e) begin
        failures++;
        $display("FAIL blank_pixel k=%0d h=%0d: got %h expected %h", cyc, h_cnt, pixel_out, e);
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    logic [45:0] rst_vec;
    rst_vec = {10'd0, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, ~POL, ~POL, 12'h000};
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (exp_h(cyc) == 5 && exp_v(cyc) == 3 && exp_f(cyc) > 0) break;
      tick();
    end
    pixel_in = 12'h000;
    #5;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== rst_vec) begin
      failures++;
      $display("FAIL mid_reset_async: got %h expected %h", obs, rst_vec);
    end
    repeat (2) @(negedge clk_25MHz);
    rst_n = 1'b1;
    cyc = -1;
    test_scan(FRAME + 20);
  endtask

  task automatic test_frame_wrap();
    int target;
    target = 256 * FRAME;
    for (int i = 0; i < target + 2 && cyc < target; i++) begin
      checks++;
      if (frame_cnt !== 8'(exp_f(cyc)) ||
          frame_start !== ((exp_h(cyc) == 0) && (exp_v(cyc) == 0))) begin
        failures++;
        $display("FAIL frame_track k=%0d: frame_cnt=%0d fs=%b expected %0d", cyc, frame_cnt,
                 frame_start, exp_f(cyc));
      end
      if (cyc == FRAME) begin
        checks++;
        if (frame_cnt !== 8'd1 || frame_start !== 1'b1) begin
          failures++;
          $display("FAIL first_frame: frame_cnt=%0d fs=%b expected 1 1", frame_cnt, frame_start);
        end
      end
      tick();
    end
    checks++;
    if (cyc != target || frame_cnt !== 8'd0 || frame_start !== 1'b1) begin
      failures++;
      $display("FAIL frame_wrap_256: k=%0d frame_cnt=%0d fs=%b expected k=%0d 0 1", cyc, frame_cnt,
               frame_start, target);
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_scan(3 * FRAME);
    test_line_wrap();
    test_sync();
    test_blank();
    test_mid_reset();
    test_frame_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(40 * 100000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog expired");
  end

endmodule
